// File: rtl/dcache_req_arb_pkg.sv
// +--------------------------------------------------------------------------+
// | dcache_req_arb_pkg: shared widths, FSM states, owner and tbus op codes    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package dcache_req_arb_pkg;
  localparam int RESULT_W      = 64;
  localparam int SRC_W         = 64;
  localparam int MASK_W        = 64;
  localparam int TBUS_OPTYPE_W = 2;
  localparam int ROB_SIZE_LOG  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_LD = 1'b0,
    OWN_ST = 1'b1
  } owner_e;

  localparam logic [TBUS_OPTYPE_W-1:0] TBUS_READ  = 2'd0;
  localparam logic [TBUS_OPTYPE_W-1:0] TBUS_WRITE = 2'd1;
endpackage

`default_nettype wire

// File: rtl/dcache_req_arb_rob_age_cmp.sv
// +--------------------------------------------------------------------------+
// | rob_age_cmp: flags a request younger than an active flush point           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module rob_age_cmp #(
  parameter int IDX_W = 6
) (
  input  logic             flush_valid,
  input  logic             flush_flag,
  input  logic [IDX_W-1:0] flush_idx,
  input  logic             req_flag,
  input  logic [IDX_W-1:0] req_idx,
  output logic             kill
);
  // Differing wrap flags invert the plain index ordering.
  assign kill = flush_valid & ((flush_flag ^ req_flag) ^ (flush_idx < req_idx));
endmodule

`default_nettype wire

// File: rtl/dcache_req_arb.sv
// +--------------------------------------------------------------------------+
// | dcache_req_arb: arbitrates load and store ports onto one trinity bus      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module dcache_req_arb
  import dcache_req_arb_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ld_index_valid,
  output logic                     ld_index_ready,
  input  logic [RESULT_W-1:0]      ld_index,
  input  logic [SRC_W-1:0]         ld_write_data,
  input  logic [MASK_W-1:0]        ld_write_mask,
  input  logic [TBUS_OPTYPE_W-1:0] ld_operation_type,
  output logic [RESULT_W-1:0]      ld_read_data,
  output logic                     ld_operation_done,
  input  logic                     st_index_valid,
  output logic                     st_index_ready,
  input  logic [RESULT_W-1:0]      st_index,
  input  logic [SRC_W-1:0]         st_write_data,
  input  logic [MASK_W-1:0]        st_write_mask,
  input  logic [TBUS_OPTYPE_W-1:0] st_operation_type,
  output logic [RESULT_W-1:0]      st_read_data,
  output logic                     st_operation_done,
  input  logic                     st_urgent,
  input  logic                     flush_valid,
  input  logic                     flush_robidx_flag,
  input  logic [ROB_SIZE_LOG-1:0]  flush_robidx,
  input  logic                     ld_robidx_flag,
  input  logic [ROB_SIZE_LOG-1:0]  ld_robidx,
  output logic                     tbus_index_valid,
  input  logic                     tbus_index_ready,
  output logic [RESULT_W-1:0]      tbus_index,
  output logic [SRC_W-1:0]         tbus_write_data,
  output logic [MASK_W-1:0]        tbus_write_mask,
  output logic [TBUS_OPTYPE_W-1:0] tbus_operation_type,
  input  logic [RESULT_W-1:0]      tbus_read_data,
  input  logic                     tbus_operation_done
);
  arb_state_e                 state_q, state_d;
  owner_e                     last_grant_q, last_grant_d;
  owner_e                     owner_q, owner_d;
  logic                       killed_q, killed_d;
  logic [RESULT_W-1:0]        index_q, index_d;
  logic [SRC_W-1:0]           wdata_q, wdata_d;
  logic [MASK_W-1:0]          wmask_q, wmask_d;
  logic [TBUS_OPTYPE_W-1:0]   optype_q, optype_d;
  logic                       rob_flag_q, rob_flag_d;
  logic [ROB_SIZE_LOG-1:0]    rob_idx_q, rob_idx_d;

  logic ld_kill_in, ld_kill_cap, cap_kill;
  logic grant_ld, grant_st, done_live, resp_ld, resp_st;

  rob_age_cmp #(.IDX_W(ROB_SIZE_LOG)) u_kill_in (
    .flush_valid (flush_valid),
    .flush_flag  (flush_robidx_flag),
    .flush_idx   (flush_robidx),
    .req_flag    (ld_robidx_flag),
    .req_idx     (ld_robidx),
    .kill        (ld_kill_in)
  );

  rob_age_cmp #(.IDX_W(ROB_SIZE_LOG)) u_kill_cap (
    .flush_valid (flush_valid),
    .flush_flag  (flush_robidx_flag),
    .flush_idx   (flush_robidx),
    .req_flag    (rob_flag_q),
    .req_idx     (rob_idx_q),
    .kill        (ld_kill_cap)
  );

  assign cap_kill  = (owner_q == OWN_LD) & ld_kill_cap;
  // Done only counts once the request has actually been accepted by the bus.
  assign done_live = tbus_operation_done &
                     (((state_q == ST_REQ) & tbus_index_ready) | (state_q == ST_WAIT));

  always_comb begin
    grant_ld = 1'b0;
    grant_st = 1'b0;
    if (!reset && state_q == ST_IDLE) begin
      if (st_index_valid && st_urgent) begin
        grant_st = 1'b1;
      end else if (st_index_valid && ld_index_valid && !ld_kill_in) begin
        grant_ld = (last_grant_q == OWN_ST);
        grant_st = (last_grant_q == OWN_LD);
      end else if (ld_index_valid && !ld_kill_in) begin
        grant_ld = 1'b1;
      end else if (st_index_valid) begin
        grant_st = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    killed_d     = killed_q;
    index_d      = index_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    optype_d     = optype_q;
    rob_flag_d   = rob_flag_q;
    rob_idx_d    = rob_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_ld) begin
          state_d    = ST_REQ;
          owner_d    = OWN_LD;
          killed_d   = 1'b0;
          index_d    = ld_index;
          wdata_d    = ld_write_data;
          wmask_d    = ld_write_mask;
          optype_d   = ld_operation_type;
          rob_flag_d = ld_robidx_flag;
          rob_idx_d  = ld_robidx;
        end else if (grant_st) begin
          state_d    = ST_REQ;
          owner_d    = OWN_ST;
          killed_d   = 1'b0;
          index_d    = st_index;
          wdata_d    = st_write_data;
          wmask_d    = st_write_mask;
          optype_d   = st_operation_type;
        end
      end
      ST_REQ: begin
        if (tbus_index_ready) begin
          if (tbus_operation_done) begin
            state_d      = ST_IDLE;
            last_grant_d = owner_q;
            killed_d     = 1'b0;
          end else begin
            state_d  = ST_WAIT;
            killed_d = cap_kill;
          end
        end else if (cap_kill) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (tbus_operation_done) begin
          state_d      = ST_IDLE;
          last_grant_d = owner_q;
          killed_d     = 1'b0;
        end else begin
          killed_d = killed_q | cap_kill;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= OWN_ST;
      owner_q      <= OWN_LD;
      killed_q     <= 1'b0;
      index_q      <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      optype_q     <= '0;
      rob_flag_q   <= 1'b0;
      rob_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      killed_q     <= killed_d;
      index_q      <= index_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      optype_q     <= optype_d;
      rob_flag_q   <= rob_flag_d;
      rob_idx_q    <= rob_idx_d;
    end
  end

  assign ld_index_ready = grant_ld;
  assign st_index_ready = grant_st;

  assign tbus_index_valid    = !reset && (state_q == ST_REQ);
  assign tbus_index          = reset ? '0 : index_q;
  assign tbus_write_data     = reset ? '0 : wdata_q;
  assign tbus_write_mask     = reset ? '0 : wmask_q;
  assign tbus_operation_type = reset ? '0 : optype_q;

  assign resp_ld = !reset && (state_q != ST_IDLE) && (owner_q == OWN_LD);
  assign resp_st = !reset && (state_q != ST_IDLE) && (owner_q == OWN_ST);

  assign ld_operation_done = resp_ld & done_live & !killed_q & !cap_kill;
  assign st_operation_done = resp_st & done_live;
  assign ld_read_data      = resp_ld ? tbus_read_data : '0;
  assign st_read_data      = resp_st ? tbus_read_data : '0;
endmodule

`default_nettype wire

// File: tb/tb_dcache_req_arb.sv
// +--------------------------------------------------------------------------+
// | tb_dcache_req_arb: directed scenarios with a response-data scoreboard     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dcache_req_arb;
  import dcache_req_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        ld_index_valid, ld_index_ready, ld_operation_done;
  logic [63:0] ld_index, ld_write_data, ld_write_mask, ld_read_data;
  logic [1:0]  ld_operation_type;
  logic        st_index_valid, st_index_ready, st_operation_done, st_urgent;
  logic [63:0] st_index, st_write_data, st_write_mask, st_read_data;
  logic [1:0]  st_operation_type;
  logic        flush_valid, flush_robidx_flag, ld_robidx_flag;
  logic [5:0]  flush_robidx, ld_robidx;
  logic        tbus_index_valid, tbus_index_ready, tbus_operation_done;
  logic [63:0] tbus_index, tbus_write_data, tbus_write_mask, tbus_read_data;
  logic [1:0]  tbus_operation_type;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_data;

  always #5 clock = ~clock;

  dcache_req_arb dut (
    .clock(clock), .reset(reset),
    .ld_index_valid(ld_index_valid), .ld_index_ready(ld_index_ready),
    .ld_index(ld_index), .ld_write_data(ld_write_data), .ld_write_mask(ld_write_mask),
    .ld_operation_type(ld_operation_type), .ld_read_data(ld_read_data),
    .ld_operation_done(ld_operation_done),
    .st_index_valid(st_index_valid), .st_index_ready(st_index_ready),
    .st_index(st_index), .st_write_data(st_write_data), .st_write_mask(st_write_mask),
    .st_operation_type(st_operation_type), .st_read_data(st_read_data),
    .st_operation_done(st_operation_done), .st_urgent(st_urgent),
    .flush_valid(flush_valid), .flush_robidx_flag(flush_robidx_flag),
    .flush_robidx(flush_robidx), .ld_robidx_flag(ld_robidx_flag), .ld_robidx(ld_robidx),
    .tbus_index_valid(tbus_index_valid), .tbus_index_ready(tbus_index_ready),
    .tbus_index(tbus_index), .tbus_write_data(tbus_write_data),
    .tbus_write_mask(tbus_write_mask), .tbus_operation_type(tbus_operation_type),
    .tbus_read_data(tbus_read_data), .tbus_operation_done(tbus_operation_done)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    ld_index_valid = 0; ld_index = '0; ld_write_data = '0; ld_write_mask = '0;
    ld_operation_type = TBUS_READ; ld_robidx_flag = 0; ld_robidx = 6'd3;
    st_index_valid = 0; st_index = '0; st_write_data = '0; st_write_mask = '0;
    st_operation_type = TBUS_WRITE; st_urgent = 0;
    flush_valid = 0; flush_robidx_flag = 0; flush_robidx = '0;
    tbus_index_ready = 0; tbus_operation_done = 0; tbus_read_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    repeat (2) cyc();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    ld_index_valid = 1; ld_index = 64'h1234;
    cyc();
    mid();
    n_cmp++; if (ld_index_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ld_ready: got %b want 0", ld_index_ready); end
    n_cmp++; if (tbus_index_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tbus_valid: got %b want 0", tbus_index_valid); end
    n_cmp++; if (tbus_index !== 64'h0) begin n_fail++; $display("FAIL rst_tbus_index: got %h want 0", tbus_index); end
    cyc();
    reset = 0; ld_index_valid = 0;
    mid();
    n_cmp++; if (tbus_index_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid: got %b want 0", tbus_index_valid); end
  endtask

  task automatic test_lone_load();
    cyc();
    ld_index_valid = 1; ld_index = 64'h8000_0010; ld_operation_type = TBUS_READ;
    mid();
    n_cmp++; if (ld_index_ready !== 1'b1) begin n_fail++; $display("FAIL lone_ready: got %b want 1", ld_index_ready); end
    n_cmp++; if (tbus_index_valid !== 1'b0) begin n_fail++; $display("FAIL lone_valid_early: got %b want 0", tbus_index_valid); end
    cyc();
    ld_index_valid = 0; tbus_index_ready = 1;
    mid();
    n_cmp++; if (tbus_index_valid !== 1'b1 || tbus_index !== 64'h8000_0010 || tbus_operation_type !== TBUS_READ)
      begin n_fail++; $display("FAIL lone_req: valid=%b idx=%h op=%0d want 1/80000010/%0d", tbus_index_valid, tbus_index, tbus_operation_type, TBUS_READ); end
    cyc();
    tbus_index_ready = 0;
    mid();
    n_cmp++; if (tbus_index_valid !== 1'b0) begin n_fail++; $display("FAIL lone_wait_valid: got %b want 0", tbus_index_valid); end
    cyc();
    tbus_operation_done = 1; tbus_read_data = 64'hDEAD_BEEF; sb.push_back(64'hDEAD_BEEF);
    mid();
    exp_data = sb.pop_front();
    n_cmp++; if (ld_operation_done !== 1'b1 || ld_read_data !== exp_data)
      begin n_fail++; $display("FAIL lone_resp: done=%b data=%h want 1/%h", ld_operation_done, ld_read_data, exp_data); end
    n_cmp++; if (st_read_data !== 64'h0 || st_operation_done !== 1'b0)
      begin n_fail++; $display("FAIL lone_nonowner: st_done=%b st_data=%h want 0/0", st_operation_done, st_read_data); end
    cyc();
    tbus_operation_done = 0; tbus_read_data = '0;
    mid();
    n_cmp++; if (ld_operation_done !== 1'b0) begin n_fail++; $display("FAIL lone_single_pulse: got %b want 0", ld_operation_done); end
  endtask

  task automatic test_round_robin();
    do_reset();
    ld_index_valid = 1; ld_index = 64'h2000;
    st_index_valid = 1; st_index = 64'h100; st_write_data = 64'h1234; st_write_mask = 64'hFF00;
    mid();
    n_cmp++; if (ld_index_ready !== 1'b1 || st_index_ready !== 1'b0)
      begin n_fail++; $display("FAIL rr_first: ld_rdy=%b st_rdy=%b want 1/0", ld_index_ready, st_index_ready); end
    cyc();
    ld_index_valid = 0; tbus_index_ready = 1;
    mid();
    n_cmp++; if (tbus_index !== 64'h2000 || st_index_ready !== 1'b0)
      begin n_fail++; $display("FAIL rr_ld_req: idx=%h st_rdy=%b want 2000/0", tbus_index, st_index_ready); end
    cyc();
    tbus_index_ready = 0; tbus_operation_done = 1; tbus_read_data = 64'hA5; sb.push_back(64'hA5);
    mid();
    exp_data = sb.pop_front();
    n_cmp++; if (ld_operation_done !== 1'b1 || ld_read_data !== exp_data || st_index_ready !== 1'b0)
      begin n_fail++; $display("FAIL rr_ld_resp: done=%b data=%h st_rdy=%b want 1/%h/0", ld_operation_done, ld_read_data, st_index_ready, exp_data); end
    cyc();
    tbus_operation_done = 0;
    mid();
    n_cmp++; if (st_index_ready !== 1'b1) begin n_fail++; $display("FAIL rr_st_grant: got %b want 1", st_index_ready); end
    cyc();
    st_index_valid = 0; tbus_index_ready = 1; tbus_operation_done = 1; tbus_read_data = 64'h55; sb.push_back(64'h55);
    mid();
    n_cmp++; if (tbus_index_valid !== 1'b1 || tbus_write_mask !== 64'hFF00 || tbus_index !== 64'h100 ||
                 tbus_write_data !== 64'h1234 || tbus_operation_type !== TBUS_WRITE)
      begin n_fail++; $display("FAIL rr_st_req: v=%b mask=%h idx=%h wd=%h op=%0d want 1/ff00/100/1234/%0d",
                              tbus_index_valid, tbus_write_mask, tbus_index, tbus_write_data, tbus_operation_type, TBUS_WRITE); end
    exp_data = sb.pop_front();
    n_cmp++; if (st_operation_done !== 1'b1 || st_read_data !== exp_data || ld_operation_done !== 1'b0)
      begin n_fail++; $display("FAIL rr_st_resp: done=%b data=%h ld_done=%b want 1/%h/0", st_operation_done, st_read_data, ld_operation_done, exp_data); end
    cyc();
    tbus_index_ready = 0; tbus_operation_done = 0;
    mid();
    n_cmp++; if (tbus_index_valid !== 1'b0 || st_operation_done !== 1'b0)
      begin n_fail++; $display("FAIL rr_same_cycle_idle: v=%b done=%b want 0/0", tbus_index_valid, st_operation_done); end
  endtask

  task automatic test_urgent();
    // Store was served last, so only urgency lets it win here.
    cyc();
    ld_index_valid = 1; ld_index = 64'h3000;
    st_index_valid = 1; st_urgent = 1; st_index = 64'h400; st_write_mask = 64'h0F;
    mid();
    n_cmp++; if (st_index_ready !== 1'b1 || ld_index_ready !== 1'b0)
      begin n_fail++; $display("FAIL urg_grant: st_rdy=%b ld_rdy=%b want 1/0", st_index_ready, ld_index_ready); end
    cyc();
    st_urgent = 0; tbus_index_ready = 1; tbus_operation_done = 1; tbus_read_data = 64'h77; sb.push_back(64'h77);
    mid();
    exp_data = sb.pop_front();
    n_cmp++; if (tbus_index !== 64'h400 || ld_index_ready !== 1'b0 || st_index_ready !== 1'b0 || st_read_data !== exp_data)
      begin n_fail++; $display("FAIL urg_req: idx=%h ld_rdy=%b st_rdy=%b data=%h want 400/0/0/%h", tbus_index, ld_index_ready, st_index_ready, st_read_data, exp_data); end
    cyc();
    tbus_index_ready = 0; tbus_operation_done = 0;
    mid();
    n_cmp++; if (ld_index_ready !== 1'b1 || st_index_ready !== 1'b0)
      begin n_fail++; $display("FAIL rr_ld_turn: ld_rdy=%b st_rdy=%b want 1/0", ld_index_ready, st_index_ready); end
    cyc();
    ld_index_valid = 0; st_index_valid = 0;
    tbus_index_ready = 1; tbus_operation_done = 1; tbus_read_data = 64'h99; sb.push_back(64'h99);
    mid();
    exp_data = sb.pop_front();
    n_cmp++; if (tbus_index !== 64'h3000 || ld_operation_done !== 1'b1 || ld_read_data !== exp_data)
      begin n_fail++; $display("FAIL rr_ld_resp2: idx=%h done=%b data=%h want 3000/1/%h", tbus_index, ld_operation_done, ld_read_data, exp_data); end
    cyc();
    tbus_index_ready = 0; tbus_operation_done = 0;
    ld_index_valid = 1; st_index_valid = 1;
    mid();
    n_cmp++; if (st_index_ready !== 1'b1 || ld_index_ready !== 1'b0)
      begin n_fail++; $display("FAIL rr_st_turn: st_rdy=%b ld_rdy=%b want 1/0", st_index_ready, ld_index_ready); end
    cyc();
    ld_index_valid = 0; st_index_valid = 0;
    tbus_index_ready = 1; tbus_operation_done = 1; tbus_read_data = 64'h11; sb.push_back(64'h11);
    mid();
    exp_data = sb.pop_front();
    n_cmp++; if (st_operation_done !== 1'b1 || st_read_data !== exp_data)
      begin n_fail++; $display("FAIL rr_st_resp2: done=%b data=%h want 1/%h", st_operation_done, st_read_data, exp_data); end
    cyc();
    tbus_index_ready = 0; tbus_operation_done = 0;
  endtask

  task automatic test_flush_req();
    ld_index_valid = 1; ld_index = 64'h5000; ld_robidx_flag = 0; ld_robidx = 6'd5;
    mid();
    n_cmp++; if (ld_index_ready !== 1'b1) begin n_fail++; $display("FAIL fr_grant: got %b want 1", ld_index_ready); end
    cyc();
    ld_index_valid = 0;
    for (int i = 0; i < 2; i++) begin
      mid();
      n_cmp++; if (tbus_index_valid !== 1'b1 || tbus_index !== 64'h5000)
        begin n_fail++; $display("FAIL fr_hold: v=%b idx=%h want 1/5000", tbus_index_valid, tbus_index); end
      cyc();
    end
    flush_valid = 1; flush_robidx_flag = 0; flush_robidx = 6'd2;
    mid();
    n_cmp++; if (ld_operation_done !== 1'b0) begin n_fail++; $display("FAIL fr_no_done: got %b want 0", ld_operation_done); end
    cyc();
    // Flush still active: a young load is refused while a store is unaffected.
    ld_index_valid = 1; st_index_valid = 1; st_index = 64'h600;
    mid();
    n_cmp++; if (tbus_index_valid !== 1'b0 || ld_index_ready !== 1'b0 || st_index_ready !== 1'b1)
      begin n_fail++; $display("FAIL fr_idle: v=%b ld_rdy=%b st_rdy=%b want 0/0/1", tbus_index_valid, ld_index_ready, st_index_ready); end
    cyc();
    ld_index_valid = 0; st_index_valid = 0;
    tbus_index_ready = 1; tbus_operation_done = 1; tbus_read_data = 64'h33; sb.push_back(64'h33);
    mid();
    exp_data = sb.pop_front();
    n_cmp++; if (st_operation_done !== 1'b1 || st_read_data !== exp_data || tbus_index !== 64'h600)
      begin n_fail++; $display("FAIL fr_store: done=%b data=%h idx=%h want 1/%h/600", st_operation_done, st_read_data, tbus_index, exp_data); end
    cyc();
    flush_valid = 0; tbus_index_ready = 0; tbus_operation_done = 0;
  endtask

  task automatic test_flush_wait();
    ld_index_valid = 1; ld_index = 64'h6000; ld_robidx = 6'd5;
    mid();
    n_cmp++; if (ld_index_ready !== 1'b1) begin n_fail++; $display("FAIL fw_grant: got %b want 1", ld_index_ready); end
    cyc();
    ld_index_valid = 0; tbus_index_ready = 1;
    cyc();
    tbus_index_ready = 0; flush_valid = 1; flush_robidx = 6'd2;
    cyc();
    flush_valid = 0;
    repeat (3) cyc();
    tbus_operation_done = 1; tbus_read_data = 64'hBAD;
    mid();
    n_cmp++; if (ld_operation_done !== 1'b0) begin n_fail++; $display("FAIL fw_suppressed: got %b want 0", ld_operation_done); end
    cyc();
    tbus_operation_done = 0;
    ld_index_valid = 1; ld_index = 64'h6100; ld_robidx = 6'd6;
    mid();
    n_cmp++; if (ld_index_ready !== 1'b1) begin n_fail++; $display("FAIL fw_next_grant: got %b want 1", ld_index_ready); end
    cyc();
    ld_index_valid = 0; tbus_index_ready = 1; tbus_operation_done = 1; tbus_read_data = 64'h42; sb.push_back(64'h42);
    mid();
    exp_data = sb.pop_front();
    n_cmp++; if (ld_operation_done !== 1'b1 || ld_read_data !== exp_data)
      begin n_fail++; $display("FAIL fw_next_resp: done=%b data=%h want 1/%h", ld_operation_done, ld_read_data, exp_data); end
    cyc();
    tbus_index_ready = 0; tbus_operation_done = 0;
  endtask

  task automatic test_reset_in_wait();
    ld_index_valid = 1; ld_index = 64'h7000;
    cyc();
    ld_index_valid = 0; tbus_index_ready = 1;
    cyc();
    tbus_index_ready = 0; reset = 1; tbus_read_data = 64'h5A;
    mid();
    n_cmp++; if (tbus_index_valid !== 1'b0 || tbus_index !== 64'h0 || ld_read_data !== 64'h0 || ld_operation_done !== 1'b0)
      begin n_fail++; $display("FAIL rw_outputs: v=%b idx=%h data=%h done=%b want all 0", tbus_index_valid, tbus_index, ld_read_data, ld_operation_done); end
    cyc();
    reset = 0; tbus_operation_done = 1;
    mid();
    n_cmp++; if (ld_operation_done !== 1'b0 || ld_read_data !== 64'h0 || tbus_index_valid !== 1'b0)
      begin n_fail++; $display("FAIL rw_late_done: done=%b data=%h v=%b want 0/0/0", ld_operation_done, ld_read_data, tbus_index_valid); end
    cyc();
    tbus_operation_done = 0; tbus_read_data = '0;
  endtask

  initial begin
    test_reset();
    test_lone_load();
    test_round_robin();
    test_urgent();
    test_flush_req();
    test_flush_wait();
    test_reset_in_wait();
    n_cmp++; if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_drain: got %0d pending want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/dcache_req_arb.md
DCACHE_REQ_ARB -- requirements
Module: dcache_req_arb

Interface
REQ-001 Parameter: none. Widths come from `defines.sv`: `RESULT_RANGE`, `SRC_RANGE`, `TBUS_OPTYPE_RANGE`, `ROB_SIZE_LOG`.
REQ-002 Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
REQ-003 Load port (ld_*, from the load unit):
- ld_index_valid  in  1  load request valid
- ld_index_ready  out  1  load request accepted
- ld_index  in  `RESULT_RANGE`  load address
- ld_write_data  in  `SRC_RANGE`  ignored for reads
- ld_write_mask  in  64  ignored for reads
- ld_operation_type  in  `TBUS_OPTYPE_RANGE`  operation type
- ld_read_data  out  `RESULT_RANGE`  read data returned
- ld_operation_done  out  1  load operation complete
REQ-004 Store port (st_*, from the store-queue commit): the same eight signals as REQ-003, with the st_ prefix.
REQ-005 st_urgent  in  1  store queue is near full; the store port wins arbitration.
REQ-006 Flush and age inputs:
- flush_valid  in  1  redirect flush
- flush_robidx_flag  in  1  flush ROB index wrap flag
- flush_robidx  in  `ROB_SIZE_LOG`  flush ROB index
- ld_robidx_flag  in  1  ROB wrap flag of the load request
- ld_robidx  in  `ROB_SIZE_LOG`  ROB index of the load request
REQ-007 Shared trinity bus port (tbus_*):
- tbus_index_valid  out  1  request valid
- tbus_index_ready  in  1  request accepted
- tbus_index  out  `RESULT_RANGE`  address
- tbus_write_data  out  `SRC_RANGE`  write data
- tbus_write_mask  out  64  write byte-lane mask
- tbus_operation_type  out  `TBUS_OPTYPE_RANGE`  operation type
- tbus_read_data  in  `RESULT_RANGE`  read data
- tbus_operation_done  in  1  operation complete

Function
REQ-008 FSM states: IDLE, REQ (tbus_index_valid high, waiting for tbus_index_ready), WAIT (waiting for tbus_operation_done).
REQ-009 In IDLE the block grants at most one requester per cycle, and the grant is combinational:
- st_urgent=1 with st valid: store wins.
- Both valid, no urgency: round-robin. A 1-bit last_grant register gives priority to the port not served last.
- Only one valid: that port wins.
REQ-010 The granted port sees index_ready=1 in the same cycle. In every state other than IDLE both ready outputs are 0.
REQ-011 On grant, the block captures index, write_data, write_mask, operation_type, the owner (ld/st), and for loads robidx_flag/robidx. The FSM moves to REQ, so tbus_index_valid rises exactly 1 cycle after the requester handshake.
REQ-012 tbus_* request outputs are driven from these registers only. The payload stays stable while tbus_index_valid=1 and tbus_index_ready=0.
REQ-013 REQ with tbus_index_ready=1: go to WAIT. If tbus_operation_done=1 in the same cycle, the operation completes and the FSM goes directly to IDLE.
REQ-014 WAIT with tbus_operation_done=1: go to IDLE and update last_grant to the owner.
REQ-015 Responses are routed combinationally:
- {owner}_operation_done = tbus_operation_done while the owner is busy and not killed.
- {owner}_read_data = tbus_read_data.
- Non-owner done is 0 and non-owner read_data is 0.
REQ-016 Kill condition for a load: flush_valid & ((flush_robidx_flag ^ robidx_flag) ^ (flush_robidx < robidx)). It is evaluated on the captured load index, and in IDLE on the ld_* inputs.
REQ-017 A killed load in IDLE is not granted, and ld_index_ready=0.
REQ-018 A killed load in REQ that has not been accepted (tbus_index_ready=0) drops tbus_index_valid in the next cycle and returns to IDLE.
REQ-019 A load killed in REQ in the same cycle as its acceptance, or killed in WAIT, sets a sticky killed bit. The FSM still waits for tbus_operation_done, suppresses ld_operation_done, and then returns to IDLE.
REQ-020 Store operations are never killed by flush.
REQ-021 No new grant occurs in the cycle the FSM returns to IDLE; the earliest next grant is the following cycle.

Reset
REQ-022 While reset=1 and on the first cycle after it:
- FSM=IDLE, last_grant=st (so the load port has first priority).
- killed=0, owner=ld.
- All captured registers are 0.
- All outputs are 0.
REQ-023 Reset asserted mid-operation abandons the transaction immediately. A tbus_operation_done that arrives after reset is ignored.

Structure
REQ-024 The FSM state enum, the owner encoding, and the tbus operation-type codes (READ, WRITE) belong in the shared package/defines header and are not local.
REQ-025 The ROB-age kill compare is one sub-module, rob_age_cmp. It is reusable by the load unit and the store queue.

Verification
REQ-026 The bench covers these directed scenarios:
- Lone load, addr 0x8000_0010: ld_index_ready same cycle, tbus_index_valid 1 cycle later, then done with data 0xDEADBEEF → ld_read_data=0xDEADBEEF, ld_operation_done pulses once.
- Load and store valid together after reset, no urgency: load granted first. Store granted the cycle after IDLE re-entry, with write_mask 0xFF00 forwarded unchanged.
- Both valid with st_urgent=1 and last_grant=st: store granted.
- Load in REQ, tbus_index_ready=0 for 3 cycles, flush with older robidx (flag equal, flush_robidx=2, ld_robidx=5): tbus_index_valid drops, no ld_operation_done, FSM in IDLE.
- Load in WAIT flushed, done arrives 4 cycles later: ld_operation_done stays 0 and the next request is accepted afterwards.
- tbus_index_ready and tbus_operation_done high in the same cycle: single done pulse, IDLE next cycle. Reset asserted in WAIT: all outputs 0, and a late done is ignored.
